// File: rtl/bitmap_addr_gen_if.sv
// Bus bundle for the bitmap address generator:
// CPU/config side in, video RAM address and flags out.
interface bitmap_addr_gen_if #(
  parameter int ADDR_W = 15,
  parameter int PW     = 1
);
  logic              ce2H;
  logic [15:0]       BA;
  logic [7:0]        BD;
  logic              BITMDn;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic              AXn;
  logic              XINCn;
  logic              AYn;
  logic              YINCn;
  logic [ADDR_W-1:0] DRBA;
  logic [PW-1:0]     PIXA;
  logic              x_wrap;
  logic              y_wrap;

  modport master (
    output ce2H, BA, BD, BITMDn, cfg_we, cfg_addr,
    output AXn, XINCn, AYn, YINCn,
    input  DRBA, PIXA, x_wrap, y_wrap
  );

  modport slave (
    input  ce2H, BA, BD, BITMDn, cfg_we, cfg_addr,
    input  AXn, XINCn, AYn, YINCn,
    output DRBA, PIXA, x_wrap, y_wrap
  );
endinterface

// File: rtl/bitmap_addr_gen.sv
// Bitmap X/Y coordinate counters with programmable step,
// limit, wrap/clamp and raster carry into Y.
module bitmap_addr_gen #(
  parameter int X_WIDTH  = 8,
  parameter int Y_WIDTH  = 8,
  parameter int PIX_BITS = 1,
  parameter int ADDR_W   = Y_WIDTH + X_WIDTH - PIX_BITS
) (
  input logic         clk,
  input logic         reset,
  bitmap_addr_gen_if.slave bus
);

  localparam int XW = X_WIDTH;
  localparam int YW = Y_WIDTH;

  logic [XW-1:0] x_q, x_d, xstep_q, xstep_d, xmax_q, xmax_d;
  logic [YW-1:0] y_q, y_d, ystep_q, ystep_d, ymax_q, ymax_d;
  logic [2:0]    mode_q, mode_d;
  logic          x_wrap_q, x_wrap_d, y_wrap_q, y_wrap_d;

  logic          xs, ys, wx, wy, carry;
  logic [8:0]    xr, yr;
  logic          unused_bus;

  // {flag, next} on 10-bit math so limits never alias
  function automatic logic [8:0] step_f(
    input logic [7:0] v,
    input logic [7:0] st,
    input logic [7:0] mx,
    input logic       dn,
    input logic       cl
  );
    logic [9:0] s, v10, m10, r;
    logic       f;
    v10 = {2'b00, v};
    m10 = {2'b00, mx};
    s   = (st < mx) ? {2'b00, st} : m10;
    r   = v10;
    f   = 1'b0;
    if (s != 10'd0) begin
      if (!dn) begin
        r = v10 + s;
        if (r > m10) begin
          f = 1'b1;
          r = cl ? m10 : r - m10 - 10'd1;
        end
      end else if (s > v10) begin
        f = 1'b1;
        r = cl ? 10'd0 : v10 + m10 + 10'd1 - s;
      end else begin
        r = v10 - s;
      end
    end
    return {f, r[7:0]};
  endfunction

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    xstep_d  = xstep_q;
    ystep_d  = ystep_q;
    xmax_d   = xmax_q;
    ymax_d   = ymax_q;
    mode_d   = mode_q;
    x_wrap_d = 1'b0;
    y_wrap_d = 1'b0;

    wx = bus.cfg_we & (bus.cfg_addr == 3'd0);
    wy = bus.cfg_we & (bus.cfg_addr == 3'd1);
    xs = bus.ce2H & ~bus.BITMDn & ~bus.AXn;
    xr = step_f(8'(x_q), 8'(xstep_q), 8'(xmax_q),
                bus.XINCn, mode_q[0]);
    carry = xs & ~wx & xr[8] & mode_q[2] & ~mode_q[0];
    ys = (bus.ce2H & ~bus.BITMDn & ~bus.AYn) | carry;
    yr = step_f(8'(y_q), 8'(ystep_q), 8'(ymax_q),
                bus.YINCn, mode_q[1]);

    if (wx) begin
      x_d = bus.BD[XW-1:0];
    end else if (xs) begin
      x_d      = xr[XW-1:0];
      x_wrap_d = xr[8];
    end

    if (wy) begin
      y_d = bus.BD[YW-1:0];
    end else if (ys) begin
      y_d      = yr[YW-1:0];
      y_wrap_d = yr[8];
    end

    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        3'd2:    xstep_d = bus.BD[XW-1:0];
        3'd3:    ystep_d = bus.BD[YW-1:0];
        3'd4:    xmax_d  = bus.BD[XW-1:0];
        3'd5:    ymax_d  = bus.BD[YW-1:0];
        3'd6:    mode_d  = bus.BD[2:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      xstep_q  <= XW'(1);
      ystep_q  <= YW'(1);
      xmax_q   <= '1;
      ymax_q   <= '1;
      mode_q   <= '0;
      x_wrap_q <= 1'b0;
      y_wrap_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      xstep_q  <= xstep_d;
      ystep_q  <= ystep_d;
      xmax_q   <= xmax_d;
      ymax_q   <= ymax_d;
      mode_q   <= mode_d;
      x_wrap_q <= x_wrap_d;
      y_wrap_q <= y_wrap_d;
    end
  end

  assign bus.DRBA = bus.BITMDn ? bus.BA[ADDR_W-1:0]
                               : {y_q, x_q[XW-1:PIX_BITS]};

  if (PIX_BITS == 0) begin : g_nopix
    assign bus.PIXA = 1'b0;
  end else begin : g_pix
    assign bus.PIXA = x_q[PIX_BITS-1:0];
  end

  assign bus.x_wrap = x_wrap_q;
  assign bus.y_wrap = y_wrap_q;
  assign unused_bus = ^{bus.BA, bus.BD};

endmodule

// File: tb/tb_bitmap_addr_gen.sv
// Vector table plus scoreboard for bitmap_addr_gen,
// with a second small-width instance for DRBA packing.
module tb_bitmap_addr_gen;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bitmap_addr_gen_if #(.ADDR_W(15), .PW(1)) b1 ();
  bitmap_addr_gen_if #(.ADDR_W(9),  .PW(2)) b2 ();

  bitmap_addr_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  bitmap_addr_gen #(
    .X_WIDTH (6),
    .Y_WIDTH (5),
    .PIX_BITS(2)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
  );

  typedef struct {
    logic       cfg;
    logic [2:0] a;
    logic [7:0] d;
    logic       ce, bm, axn, xin, ayn, yin;
    logic [7:0] ex, ey;
    logic       exw, eyw;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] x, y;
    logic       xw, yw;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  function automatic vec_t V(
    input logic cfg, input logic [2:0] a, input logic [7:0] d,
    input logic ce, input logic bm, input logic axn,
    input logic xin, input logic ayn, input logic yin,
    input logic [7:0] ex, input logic [7:0] ey,
    input logic exw, input logic eyw
  );
    vec_t v;
    v.cfg = cfg; v.a = a; v.d = d;
    v.ce = ce; v.bm = bm; v.axn = axn;
    v.xin = xin; v.ayn = ayn; v.yin = yin;
    v.ex = ex; v.ey = ey; v.exw = exw; v.eyw = eyw;
    return v;
  endfunction

  task automatic idle();
    b1.ce2H = 1'b0; b1.BA = '0; b1.BD = '0;
    b1.BITMDn = 1'b0; b1.cfg_we = 1'b0; b1.cfg_addr = '0;
    b1.AXn = 1'b1; b1.XINCn = 1'b0;
    b1.AYn = 1'b1; b1.YINCn = 1'b0;
  endtask

  task automatic push(input int id, input logic [7:0] x,
                      input logic [7:0] y, input logic xw,
                      input logic yw);
    exp_t e;
    e.id = id; e.x = x; e.y = y; e.xw = xw; e.yw = yw;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    logic [7:0] gx, gy;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty got nothing to compare");
      return;
    end
    e  = sb.pop_front();
    gx = {b1.DRBA[6:0], b1.PIXA};
    gy = b1.DRBA[14:7];
    if ({gx, gy} !== {e.x, e.y}) begin
      bad++;
      $display("FAIL pos#%0d got x=%h y=%h want x=%h y=%h",
               e.id, gx, gy, e.x, e.y);
    end
    total++;
    if ({b1.x_wrap, b1.y_wrap} !== {e.xw, e.yw}) begin
      bad++;
      $display("FAIL flags#%0d got xw=%b yw=%b want xw=%b yw=%b",
               e.id, b1.x_wrap, b1.y_wrap, e.xw, e.yw);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    b1.cfg_we = v.cfg; b1.cfg_addr = v.a; b1.BD = v.d;
    b1.ce2H = v.ce; b1.BITMDn = v.bm;
    b1.AXn = v.axn; b1.XINCn = v.xin;
    b1.AYn = v.ayn; b1.YINCn = v.yin;
    push(id, v.ex, v.ey, v.exw, v.eyw);
    @(posedge clk); #1;
    idle();
    #1;
    check_pop();
  endtask

  task automatic w2(input logic [2:0] a, input logic [7:0] d);
    b2.cfg_we = 1'b1; b2.cfg_addr = a; b2.BD = d;
    @(posedge clk); #1;
    b2.cfg_we = 1'b0;
  endtask

  initial begin
    logic [8:0] want_drba;
    logic [1:0] want_pixa;

    // cfg(a,d) ce bm axn xin ayn yin -> x y xw yw
    vt.push_back(V(1,0,8'hFF, 0,1, 1,0,1,0, 8'hFF,8'h00,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,0,1,0, 8'h00,8'h00,1,0));
    vt.push_back(V(0,0,8'h00, 0,0, 1,0,1,0, 8'h00,8'h00,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,1,1,0, 8'hFF,8'h00,1,0));
    vt.push_back(V(0,0,8'h00, 1,1, 0,0,0,0, 8'hFF,8'h00,0,0));
    vt.push_back(V(0,0,8'h00, 0,0, 0,0,0,0, 8'hFF,8'h00,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 1,0,0,0, 8'hFF,8'h01,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 1,0,0,1, 8'hFF,8'h00,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 1,0,0,1, 8'hFF,8'hFF,0,1));
    vt.push_back(V(1,1,8'h00, 0,0, 1,0,1,0, 8'hFF,8'h00,0,0));
    vt.push_back(V(1,4,8'h09, 0,0, 1,0,1,0, 8'hFF,8'h00,0,0));
    vt.push_back(V(1,2,8'h03, 0,0, 1,0,1,0, 8'hFF,8'h00,0,0));
    vt.push_back(V(1,0,8'h08, 0,0, 1,0,1,0, 8'h08,8'h00,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,0,1,0, 8'h01,8'h00,1,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,1,1,0, 8'h08,8'h00,1,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,1,1,0, 8'h05,8'h00,0,0));
    vt.push_back(V(1,6,8'h01, 0,0, 1,0,1,0, 8'h05,8'h00,0,0));
    vt.push_back(V(1,2,8'h04, 0,0, 1,0,1,0, 8'h05,8'h00,0,0));
    vt.push_back(V(1,0,8'h07, 0,0, 1,0,1,0, 8'h07,8'h00,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,0,1,0, 8'h09,8'h00,1,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,0,1,0, 8'h09,8'h00,1,0));
    vt.push_back(V(1,0,8'h02, 0,0, 1,0,1,0, 8'h02,8'h00,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,1,1,0, 8'h00,8'h00,1,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,1,1,0, 8'h00,8'h00,1,0));
    vt.push_back(V(1,2,8'h20, 0,0, 1,0,1,0, 8'h00,8'h00,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,0,1,0, 8'h09,8'h00,0,0));
    vt.push_back(V(1,2,8'h00, 0,0, 1,0,1,0, 8'h09,8'h00,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,0,1,0, 8'h09,8'h00,0,0));
    vt.push_back(V(1,6,8'h04, 0,0, 1,0,1,0, 8'h09,8'h00,0,0));
    vt.push_back(V(1,4,8'h03, 0,0, 1,0,1,0, 8'h09,8'h00,0,0));
    vt.push_back(V(1,2,8'h01, 0,0, 1,0,1,0, 8'h09,8'h00,0,0));
    vt.push_back(V(1,0,8'h03, 0,0, 1,0,1,0, 8'h03,8'h00,0,0));
    vt.push_back(V(1,1,8'h05, 0,0, 1,0,1,0, 8'h03,8'h05,0,0));
    vt.push_back(V(1,3,8'h02, 0,0, 1,0,1,0, 8'h03,8'h05,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,0,1,0, 8'h00,8'h07,1,0));
    vt.push_back(V(1,0,8'h03, 0,0, 1,0,1,0, 8'h03,8'h07,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,0,0,0, 8'h00,8'h09,1,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,0,0,0, 8'h01,8'h0B,0,0));
    vt.push_back(V(1,4,8'hFF, 0,0, 1,0,1,0, 8'h01,8'h0B,0,0));
    vt.push_back(V(1,6,8'h00, 0,0, 1,0,1,0, 8'h01,8'h0B,0,0));
    vt.push_back(V(1,0,8'h20, 1,0, 0,0,0,0, 8'h20,8'h0D,0,0));
    vt.push_back(V(1,6,8'h04, 0,0, 1,0,1,0, 8'h20,8'h0D,0,0));
    vt.push_back(V(1,4,8'h03, 0,0, 1,0,1,0, 8'h20,8'h0D,0,0));
    vt.push_back(V(1,0,8'h03, 0,0, 1,0,1,0, 8'h03,8'h0D,0,0));
    vt.push_back(V(1,1,8'h40, 1,0, 0,0,1,0, 8'h00,8'h40,1,0));
    vt.push_back(V(1,2,8'h02, 1,0, 0,0,1,0, 8'h01,8'h40,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,0,1,0, 8'h03,8'h40,0,0));
    vt.push_back(V(1,6,8'h05, 0,0, 1,0,1,0, 8'h03,8'h40,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 0,0,1,0, 8'h03,8'h40,1,0));
    vt.push_back(V(1,6,8'h02, 0,0, 1,0,1,0, 8'h03,8'h40,0,0));
    vt.push_back(V(1,5,8'h41, 0,0, 1,0,1,0, 8'h03,8'h40,0,0));
    vt.push_back(V(0,0,8'h00, 1,0, 1,0,0,0, 8'h03,8'h41,0,1));

    idle();
    b2.ce2H = 1'b0; b2.BA = '0; b2.BD = '0;
    b2.BITMDn = 1'b0; b2.cfg_we = 1'b0; b2.cfg_addr = '0;
    b2.AXn = 1'b1; b2.XINCn = 1'b0;
    b2.AYn = 1'b1; b2.YINCn = 1'b0;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    push(1000, 8'h00, 8'h00, 1'b0, 1'b0);
    #1 check_pop();

    foreach (vt[i]) apply(vt[i], i);

    // BITMDn=1 passes the CPU address straight through
    b1.BITMDn = 1'b1; b1.BA = 16'hABCD;
    #1;
    total++;
    if (b1.DRBA !== 15'h2BCD) begin
      bad++;
      $display("FAIL drba_ba got %h want %h", b1.DRBA, 15'h2BCD);
    end
    idle();

    // reset wins over a simultaneous write and step
    reset = 1'b1;
    b1.cfg_we = 1'b1; b1.cfg_addr = 3'd0; b1.BD = 8'h55;
    b1.ce2H = 1'b1; b1.AXn = 1'b0; b1.AYn = 1'b0;
    push(1001, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    #1 check_pop();
    apply(V(0,0,8'h00, 1,0, 0,0,1,0, 8'h01,8'h00,0,0), 1002);
    apply(V(0,0,8'h00, 1,0, 1,0,0,1, 8'h01,8'hFF,0,1), 1003);

    // narrow instance: X=6b, Y=5b, 2 pixel bits
    w2(3'd0, 8'h2D);
    w2(3'd1, 8'h13);
    #1;
    want_drba = 9'h13B;
    want_pixa = 2'd1;
    total++;
    if (b2.DRBA !== want_drba) begin
      bad++;
      $display("FAIL sweep_drba got %h want %h", b2.DRBA, want_drba);
    end
    total++;
    if (b2.PIXA !== want_pixa) begin
      bad++;
      $display("FAIL sweep_pixa got %h want %h", b2.PIXA, want_pixa);
    end

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_left got %0d want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitmap_addr_gen.md
Name: bitmap_addr_gen

Overview:
Parametrised bitmap address generator for the video-RAM path. It holds X/Y pixel coordinate counters, each loaded from the CPU data bus. During bitmap-mode accesses it converts them to a byte address plus a pixel-select field. It is the generalised successor of the fixed 8x8 auto-increment unit, adding:
- configurable coordinate widths and pixels per byte;
- programmable step sizes;
- programmable axis limits with wrap or clamp;
- optional X-to-Y raster carry.

Reset defaults reproduce legacy behaviour exactly.

Parameters:
X_WIDTH, 8, X coordinate width (2..8)
Y_WIDTH, 8, Y coordinate width (1..8)
PIX_BITS, 1, low X bits selecting the pixel within a byte (0..X_WIDTH-1)
ADDR_W, Y_WIDTH+X_WIDTH-PIX_BITS, DRBA width (must be <= 16)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ce2H  in  1  clock enable for coordinate stepping
BA  in  16  CPU address bus
BD  in  8  CPU data bus (register write data)
BITMDn  in  1  bitmap-mode access, active low
cfg_we  in  1  config register write strobe, active high, one clk
cfg_addr  in  3  config register select
AXn  in  1  step X on this access, active low
XINCn  in  1  X direction: 0 = up, 1 = down
AYn  in  1  step Y on this access, active low
YINCn  in  1  Y direction: 0 = up, 1 = down
DRBA  out  ADDR_W  video RAM byte address
PIXA  out  max(PIX_BITS,1)  pixel select within byte (0 when PIX_BITS=0)
x_wrap  out  1  one-clk pulse: X wrapped or clamped at a limit
y_wrap  out  1  one-clk pulse: Y wrapped or clamped at a limit

Behaviour:
- One clock domain. Reset is synchronous and active-high; it overrides every other input.
- Config registers (written when cfg_we=1, data BD truncated to the register width):
  - 0 X
  - 1 Y
  - 2 XSTEP
  - 3 YSTEP
  - 4 XMAX
  - 5 YMAX
  - 6 MODE: bit0 X clamp, bit1 Y clamp, bit2 X->Y carry
  - 7 reserved (write ignored)
- Reset values: X=0, Y=0, XSTEP=1, YSTEP=1, XMAX and YMAX all ones, MODE=0, x_wrap=0, y_wrap=0.
- DRBA is combinational:
  - BITMDn=0: {Y, X[X_WIDTH-1:PIX_BITS]}.
  - BITMDn=1: BA[ADDR_W-1:0].
  - PIXA = X[PIX_BITS-1:0].
- X step condition: ce2H & ~BITMDn & ~AXn. X updates on the next clk edge.
- Effective step: s = min(XSTEP, XMAX). A step of 0 holds X and asserts no flag.
- Wrap mode, up: if X+s > XMAX then X' = X+s-(XMAX+1), else X' = X+s. Compute with X_WIDTH+1 bits; no truncation aliasing.
- Wrap mode, down: if s > X then X' = X+(XMAX+1)-s, else X' = X-s.
- Clamp mode: X' = min(X+s, XMAX) going up, max(X-s, 0) going down.
- x_wrap pulses in the cycle after an X step that wrapped, or that clamped with X' != X+s (up) / X-s (down).
- X outside [0,XMAX] (written directly): the step result is still computed by the rules above; no error.
- Y uses the same rules with YSTEP/YMAX/MODE bit1, step condition ce2H & ~BITMDn & ~AYn.
- Carry (MODE bit2=1, X in wrap mode): an X wrap also steps Y once by YSTEP in the YINCn direction, even if AYn=1.
  - If AYn=0 in the same cycle, Y still steps exactly once.
  - X clamp mode generates no carry.
- Priority: a cfg write to X or Y beats a simultaneous step of that axis. The other axis still steps, and a carry into a just-written Y is dropped.
- Writes to XMAX/YMAX/XSTEP/YSTEP/MODE take effect from the next clk. A step in the same cycle uses the old values.
- With ce2H=0 or BITMDn=1, coordinates hold. Flags deassert after one clk.
- Reset asserted mid-sequence restores all reset values on that edge. Any same-cycle write or step is discarded.

Test Plan:
- Reset defaults, legacy equivalence: write X=0xFF, BITMDn=0, AXn=0, XINCn=0, one ce2H -> X=0x00, x_wrap pulse. DRBA={Y,X[7:1]}. BITMDn=1 -> DRBA=BA[14:0].
- Wrap with limit: XMAX=9, XSTEP=3, X=8, step up -> X=1, x_wrap=1. Step down from X=1 -> X=8.
- Clamp: MODE=1, XMAX=9, XSTEP=4, X=7. Step up -> 9 with x_wrap=1; again -> 9 with x_wrap=1. Down from 2 -> 0.
- Raster carry: MODE=4, XMAX=3, X=3, Y=5, YSTEP=2, YINCn=0, AYn=1, step X up -> X=0, Y=7. Repeat with AYn=0 -> Y advances only 2.
- Priority: cfg write X=0x20 in the same cycle as an X step -> X=0x20. Reset with cfg_we=1 -> all registers at reset values.
- Parameter sweep: X_WIDTH=6, Y_WIDTH=5, PIX_BITS=2, X=0x2D, Y=0x13 -> DRBA=0x13B (9 bits), PIXA=1.
